// File: rtl/wb_arb2.sv
// Two-master, one-slave Wishbone classic arbiter.
// Round-robin grant that is held for the whole owner bus cycle, with a
// per-transfer ack watchdog that answers a silent slave with a one-cycle err.
//
// Handshake: a transfer is requested while cyc and stb are both high and
// completes in the cycle the slave raises ack (one pulse). The owning master
// must then drop stb or present its next transfer. The arbiter forwards stb
// and ack without buffering, so it adds no latency once the grant is held.
module wb_arb2 #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // master 0
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [SW-1:0] m0_sel_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [DW-1:0] m0_dat_o,
    // master 1
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    input  logic [SW-1:0] m1_sel_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [DW-1:0] m1_dat_o,
    // slave
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic [SW-1:0] s_sel_o,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_dat_i
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;      // 0: m0 owned last, 1: m1 owned last
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err0_q, err0_d;
    logic           err1_q, err1_d;

    logic           own0;
    logic           own1;
    logic           timeout_hit;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

    // Slave-side mux: everything is zero while idle, owner's signals otherwise.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~err0_q;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~err1_q;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // Master-side returns: ack routed to the owner only; err yields to a late ack.
    always_comb begin
        m0_ack_o = s_ack_i & own0;
        m1_ack_o = s_ack_i & own1;
        m0_err_o = err0_q & ~s_ack_i;
        m1_err_o = err1_q & ~s_ack_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

    // Grant FSM next state: round-robin from IDLE, release when owner drops cyc.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog: count stalled strobe cycles, fire a one-cycle err on expiry.
    always_comb begin
        timeout_hit = s_stb_o && !s_ack_i && (wdog_q == WDOG_LAST);
        wdog_d      = '0;
        if (s_stb_o && !s_ack_i && !timeout_hit && (state_d != IDLE)) begin
            wdog_d = wdog_q + WDW'(1);
        end
        err0_d = timeout_hit && own0 && m0_cyc_i;
        err1_d = timeout_hit && own1 && m1_cyc_i;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

endmodule
